// File: rtl/histogram_equalizer.sv
`default_nettype none
// ============================================================================
//  Module   : histogram_equalizer
//  Purpose  : Remaps one table of IDCT pixels through the CDF-based
//             equalization transfer function using a sequential divider.
//  Revision : 1.0  initial release
// ============================================================================
module histogram_equalizer #(
   parameter int IMAGE_WIDTH                 = 320,
   parameter int IMAGE_HEIGHT                = 240,
   parameter int PIXEL_WIDTH                 = 8,
   parameter int DC_OFFSET                   = 128,
   parameter int TABLE_SIZE                  = 64,
   parameter int HISTOGRAM_RAM_ADDRESS_WIDTH = PIXEL_WIDTH,
   parameter int HISTOGRAM_RAM_DATA_WIDTH    = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT)
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [TABLE_SIZE*PIXEL_WIDTH-1:0]      image_table,
   input  logic                                   start_equalize,
   input  logic [HISTOGRAM_RAM_DATA_WIDTH-1:0]    CDF_min,
   input  logic [HISTOGRAM_RAM_DATA_WIDTH-1:0]    histogram_RAM_data_input,
   output logic [HISTOGRAM_RAM_ADDRESS_WIDTH-1:0] histogram_RAM_address,
   output logic                                   histogram_RAM_CE,
   output logic [TABLE_SIZE*PIXEL_WIDTH-1:0]      equalized_table,
   output logic                                   equalized_valid,
   output logic                                   busy
);

   localparam int PW   = PIXEL_WIDTH;
   localparam int AW   = HISTOGRAM_RAM_ADDRESS_WIDTH;
   localparam int DW   = HISTOGRAM_RAM_DATA_WIDTH;
   localparam int NW   = DW + PW;
   localparam int DENW = DW + 1;
   localparam int KW   = (TABLE_SIZE > 1) ? $clog2(TABLE_SIZE) : 1;
   localparam int CW   = (NW > 1) ? $clog2(NW) : 1;

   localparam logic [DENW-1:0] c_num_pixels = DENW'(IMAGE_WIDTH * IMAGE_HEIGHT);
   localparam logic [PW-1:0]   c_max_pixel  = {PW{1'b1}};
   localparam logic [KW-1:0]   c_last_k     = KW'(TABLE_SIZE - 1);
   localparam logic [CW-1:0]   c_last_bit   = CW'(NW - 1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_READ    = 3'd1,
      ST_CAPTURE = 3'd2,
      ST_DIVIDE  = 3'd3,
      ST_STORE   = 3'd4
   } state_t;

   state_t                          r_state;
   logic [TABLE_SIZE*PW-1:0]        r_image;
   logic [DW-1:0]                   r_cdf_min;
   logic [KW-1:0]                   r_k;
   logic [NW-1:0]                   r_quot;
   logic [DENW-1:0]                 r_rem;
   logic [DENW-1:0]                 r_den;
   logic [CW-1:0]                   r_cnt;
   logic                            r_under;
   logic                            r_den_zero;
   logic [AW-1:0]                   r_addr;
   logic                            r_ce;
   logic [TABLE_SIZE*PW-1:0]        r_table;
   logic                            r_valid;
   logic                            r_busy;

   logic [KW-1:0]                   w_next_k;
   logic [PW-1:0]                   w_next_pixel;
   logic                            w_under;
   logic [DW-1:0]                   w_diff;
   logic [NW-1:0]                   w_num;
   logic [DENW-1:0]                 w_den;
   logic [DENW:0]                   w_trial;
   logic                            w_ge;
   logic [DENW-1:0]                 w_rem_next;
   logic                            w_sat;
   logic [PW-1:0]                   w_result;

   // Signed pixel plus DC offset, wrapped to the RAM address width.
   function automatic logic [AW-1:0] addr_of(input logic [PW-1:0] px);
      logic [AW-1:0] ext;
      ext = AW'(signed'(px));
      return ext + AW'(DC_OFFSET);
   endfunction

   assign w_next_k     = r_k + 1'b1;
   assign w_next_pixel = r_image[w_next_k*PW +: PW];

   assign w_under = histogram_RAM_data_input < r_cdf_min;
   assign w_diff  = histogram_RAM_data_input - r_cdf_min;
   assign w_num   = NW'(w_diff) * NW'(c_max_pixel);
   assign w_den   = c_num_pixels - {1'b0, r_cdf_min};

   // Partial remainder stays below the divisor, so DENW bits always hold it.
   assign w_trial    = {r_rem, r_quot[NW-1]};
   assign w_ge       = w_trial >= {1'b0, r_den};
   assign w_rem_next = w_ge ? DENW'(w_trial - {1'b0, r_den}) : w_trial[DENW-1:0];

   assign w_sat    = |r_quot[NW-1:PW];
   assign w_result = r_under    ? '0          :
                     r_den_zero ? c_max_pixel :
                     w_sat      ? c_max_pixel : r_quot[PW-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_image    <= '0;
         r_cdf_min  <= '0;
         r_k        <= '0;
         r_quot     <= '0;
         r_rem      <= '0;
         r_den      <= '0;
         r_cnt      <= '0;
         r_under    <= 1'b0;
         r_den_zero <= 1'b0;
         r_addr     <= '0;
         r_ce       <= 1'b0;
         r_table    <= '0;
         r_valid    <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start_equalize) begin
                  r_image   <= image_table;
                  r_cdf_min <= CDF_min;
                  r_k       <= '0;
                  r_ce      <= 1'b1;
                  r_addr    <= addr_of(image_table[PW-1:0]);
                  r_busy    <= 1'b1;
                  r_state   <= ST_READ;
               end
            end
            ST_READ: begin
               r_state <= ST_CAPTURE;
            end
            ST_CAPTURE: begin
               r_quot     <= w_num;
               r_rem      <= '0;
               r_den      <= w_den;
               r_under    <= w_under;
               r_den_zero <= (w_den == '0);
               r_cnt      <= '0;
               r_ce       <= 1'b0;
               r_addr     <= '0;
               r_state    <= ST_DIVIDE;
            end
            ST_DIVIDE: begin
               // Dividend bits shift out the top while quotient bits enter the bottom.
               r_quot <= {r_quot[NW-2:0], w_ge};
               r_rem  <= w_rem_next;
               r_cnt  <= r_cnt + 1'b1;
               if (r_cnt == c_last_bit) begin
                  r_state <= ST_STORE;
               end
            end
            ST_STORE: begin
               r_table[r_k*PW +: PW] <= w_result;
               if (r_k == c_last_k) begin
                  r_valid <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end else begin
                  r_k     <= w_next_k;
                  r_ce    <= 1'b1;
                  r_addr  <= addr_of(w_next_pixel);
                  r_state <= ST_READ;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign histogram_RAM_address = r_addr;
   assign histogram_RAM_CE      = r_ce;
   assign equalized_table       = r_table;
   assign equalized_valid       = r_valid;
   assign busy                  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_histogram_equalizer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_histogram_equalizer
//  Purpose  : Scoreboard bench for histogram_equalizer with a behavioural CDF RAM.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_histogram_equalizer;

   localparam int PW   = 8;
   localparam int TS   = 64;
   localparam int DW   = 17;
   localparam int NPIX = 320 * 240;
   localparam int LAT  = TS * (DW + PW + 3);

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start_equalize = 1'b0;
   logic [TS*PW-1:0]  image_table = '0;
   logic [DW-1:0]     CDF_min = '0;
   logic [DW-1:0]     ram_q = '0;
   logic [PW-1:0]     ram_addr;
   logic              ram_ce;
   logic [TS*PW-1:0]  eq_table;
   logic              eq_valid;
   logic              busy;

   int                checks = 0;
   int                errors = 0;
   int                cycle  = 0;
   int                mem [256];
   logic [TS*PW-1:0]  exp_q [$];
   int                cyc_q [$];
   logic              prev_valid = 1'b0;
   logic [TS*PW-1:0]  m_exp;
   int                m_c0;

   histogram_equalizer dut (
      .clk                      (clk),
      .rst                      (rst),
      .image_table              (image_table),
      .start_equalize           (start_equalize),
      .CDF_min                  (CDF_min),
      .histogram_RAM_data_input (ram_q),
      .histogram_RAM_address    (ram_addr),
      .histogram_RAM_CE         (ram_ce),
      .equalized_table          (eq_table),
      .equalized_valid          (eq_valid),
      .busy                     (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cycle <= cycle + 1;
      if (ram_ce) ram_q <= DW'(mem[ram_addr]);
   end

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   function automatic int ref_eq(input int cdf, input int cmin);
      longint den, q;
      if (cdf < cmin) return 0;
      den = longint'(NPIX - cmin) & 64'h3FFFF;
      if (den == 0) return 255;
      q = longint'(cdf - cmin) * 255 / den;
      return (q > 255) ? 255 : int'(q);
   endfunction

   function automatic logic [TS*PW-1:0] ref_table(input logic [TS*PW-1:0] img, input int cmin);
      logic [TS*PW-1:0] r;
      logic signed [PW-1:0] p;
      int a;
      r = '0;
      for (int i = 0; i < TS; i++) begin
         p = img[i*PW +: PW];
         a = (int'(p) + 128) & 255;
         r[i*PW +: PW] = PW'(ref_eq(mem[a], cmin));
      end
      return r;
   endfunction

   function automatic logic [TS*PW-1:0] rand_img();
      logic [TS*PW-1:0] r;
      for (int i = 0; i < TS; i++) r[i*PW +: PW] = PW'($urandom);
      return r;
   endfunction

   // Called at a falling edge; pulses start for one rising edge and scrambles inputs afterwards.
   task automatic issue(input logic [TS*PW-1:0] img, input int cmin, input bit accept);
      image_table    = img;
      CDF_min        = DW'(cmin);
      start_equalize = 1'b1;
      if (accept) exp_q.push_back(ref_table(img, cmin));
      @(posedge clk);
      #1;
      if (accept) cyc_q.push_back(cycle);
      start_equalize = 1'b0;
      image_table    = rand_img();
      CDF_min        = DW'($urandom_range(0, NPIX));
      @(negedge clk);
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < LAT + 200) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_timeout"}, exp_q.size(), 0);
      exp_q.delete();
      cyc_q.delete();
      @(negedge clk);
   endtask

   task automatic fill_linear();
      for (int a = 0; a < 256; a++) mem[a] = (a + 1) * 300;
   endtask

   always @(negedge clk) begin
      if (!rst && eq_valid) begin
         chk("valid_width", prev_valid, 0);
         chk("busy_at_valid", busy, 0);
         if (exp_q.size() == 0 || cyc_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid actual=1 expected=0");
         end else begin
            m_exp = exp_q.pop_front();
            m_c0  = cyc_q.pop_front();
            chk("latency", cycle - m_c0, LAT);
            for (int i = 0; i < TS; i++)
               chk($sformatf("slot%0d", i), eq_table[i*PW +: PW], m_exp[i*PW +: PW]);
         end
      end
      prev_valid <= eq_valid;
   end

   initial begin
      logic [TS*PW-1:0] img;
      int n;

      fill_linear();
      #12;
      chk("reset_busy", busy, 0);
      chk("reset_ce", ram_ce, 0);
      chk("reset_addr", ram_addr, 0);
      chk("reset_valid", eq_valid, 0);
      chk("reset_table_zero", eq_table == '0, 1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      img = rand_img();
      img[0*PW +: PW]  = 8'h80;
      img[1*PW +: PW]  = 8'h00;
      img[63*PW +: PW] = 8'h7F;
      issue(img, 300, 1'b1);
      chk("busy_after_start", busy, 1);
      wait_done("linear");
      chk("lin_slot0", eq_table[0*PW +: PW], 0);
      chk("lin_slot1", eq_table[1*PW +: PW], 128);
      chk("lin_slot63", eq_table[63*PW +: PW], 255);

      for (int t = 0; t < 3; t++) begin
         for (int a = 0; a < 256; a++) mem[a] = int'($urandom_range(0, 131071));
         issue(rand_img(), int'($urandom_range(0, NPIX)), 1'b1);
         wait_done("random");
      end

      for (int a = 0; a < 256; a++) mem[a] = NPIX;
      issue(rand_img(), NPIX, 1'b1);
      wait_done("degenerate");
      chk("degenerate_all_max", eq_table == {TS*PW{1'b1}}, 1);

      for (int a = 0; a < 256; a++) mem[a] = 500;
      issue(rand_img(), 1000, 1'b1);
      wait_done("underflow");
      chk("underflow_all_zero", eq_table == '0, 1);

      fill_linear();
      issue(rand_img(), 300, 1'b1);
      repeat (300) @(negedge clk);
      issue(rand_img(), 5000, 1'b0);
      chk("busy_ignored_start", busy, 1);
      n = 0;
      while (!eq_valid && n < LAT + 50) begin
         @(negedge clk);
         n++;
      end
      chk("valid_seen", eq_valid, 1);
      issue(rand_img(), 300, 1'b1);
      wait_done("back_to_back");

      issue(rand_img(), 300, 1'b1);
      repeat (500) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_ce", ram_ce, 0);
      chk("midrst_addr", ram_addr, 0);
      chk("midrst_valid", eq_valid, 0);
      chk("midrst_table_zero", eq_table == '0, 1);
      exp_q.delete();
      cyc_q.delete();
      @(negedge clk);
      start_equalize = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_with_start_busy", busy, 0);
      @(negedge clk);
      start_equalize = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      issue(rand_img(), 300, 1'b1);
      wait_done("after_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/histogram_equalizer.md
# histogram_equalizer

Consumes the cumulative histogram produced by the histogram/CDF stage and remaps one 8×8 table of IDCT pixels through the equalization transfer function. The function is eq = floor((CDF[v] − CDF_min)·(2^PIXEL_WIDTH−1) / (N − CDF_min)), with N = IMAGE_WIDTH·IMAGE_HEIGHT. It sits after CDF generation, shares the histogram RAM read port, and feeds equalized tables to the output/colour stage. Division is a sequential restoring divider, one quotient bit per cycle.

## Interface
- IMAGE_WIDTH, 320, image width in pixels
- IMAGE_HEIGHT, 240, image height in pixels
- PIXEL_WIDTH, 8, pixel width; also the equalized output width
- DC_OFFSET, 128, added to the signed IDCT pixel to form the RAM address
- TABLE_SIZE, 64, pixels per table
- HISTOGRAM_RAM_ADDRESS_WIDTH, PIXEL_WIDTH, CDF RAM address width
- HISTOGRAM_RAM_DATA_WIDTH, clog2(IMAGE_WIDTH·IMAGE_HEIGHT) (17), CDF word width
- clk  in  1  single clock
- rst  in  1  reset; asynchronous and active-high
- image_table  in  TABLE_SIZE·PIXEL_WIDTH  IDCT pixels; pixel i at bits [i·PIXEL_WIDTH +: PIXEL_WIDTH], two's complement
- start_equalize  in  1  start request; honoured only in IDLE
- CDF_min  in  HISTOGRAM_RAM_DATA_WIDTH  minimum CDF from the CDF stage
- histogram_RAM_data_input  in  HISTOGRAM_RAM_DATA_WIDTH  RAM read data; valid one cycle after the address is driven
- histogram_RAM_address  out  HISTOGRAM_RAM_ADDRESS_WIDTH  read address
- histogram_RAM_CE  out  1  RAM enable
- equalized_table  out  TABLE_SIZE·PIXEL_WIDTH  equalized pixels, unsigned, same indexing as image_table
- equalized_valid  out  1  one-cycle pulse when all TABLE_SIZE slots are written
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, READ, CAPTURE, DIVIDE, STORE.
- IDLE:
  - On start_equalize, latch image_table and CDF_min into internal registers, clear pixel index k to 0, and go to READ.
  - Upstream may change its inputs after the start edge.
- READ:
  - histogram_RAM_CE = 1.
  - address = (latched pixel k + DC_OFFSET) mod 2^HISTOGRAM_RAM_ADDRESS_WIDTH.
  - Next state: CAPTURE.
- CAPTURE:
  - Keep CE and the address driven. Sample histogram_RAM_data_input as cdf.
  - num = (cdf − CDF_min)·(2^PIXEL_WIDTH−1), width NW = HISTOGRAM_RAM_DATA_WIDTH + PIXEL_WIDTH.
  - den = N − CDF_min, computed at HISTOGRAM_RAM_DATA_WIDTH+1 bits.
  - Load the divider, clear the bit counter, and go to DIVIDE.
- DIVIDE:
  - Restoring division, MSB first, exactly NW cycles, then STORE.
  - CE = 0 in this state.
- STORE:
  - Write result into slot k of equalized_table.
  - If k = TABLE_SIZE−1: pulse equalized_valid and go to IDLE. Otherwise k+1, go to READ.
- Result rules:
  - cdf < CDF_min → 0.
  - den = 0 → 2^PIXEL_WIDTH−1.
  - quotient > 2^PIXEL_WIDTH−1 → saturate to 2^PIXEL_WIDTH−1.
  - Otherwise the truncated quotient.
- histogram_RAM_CE is 0 outside READ and CAPTURE. histogram_RAM_address is 0 when CE is 0. The block never writes the RAM.
- equalized_table is updated slot by slot during operation. It is meaningful only from the equalized_valid pulse until the next accepted start.
- start_equalize while busy is ignored. No queuing.

## Timing
- Reset (async assert) drives these values:
  - state IDLE, k = 0, divider registers 0.
  - equalized_table = 0, equalized_valid = 0, busy = 0.
  - histogram_RAM_CE = 0, histogram_RAM_address = 0.
- Reset mid-operation aborts immediately: no equalized_valid, previous partial table cleared.
- Per-pixel cost: NW+3 cycles (1 READ, 1 CAPTURE, NW DIVIDE, 1 STORE). With defaults NW = 25, so 28 cycles.
- Latency:
  - equalized_valid is high for exactly the one cycle starting TABLE_SIZE·(NW+3) clock edges after the start-sampling edge (1792 with defaults).
  - busy falls on that same edge.
- A start asserted in the cycle equalized_valid is high is accepted (state is IDLE). Back-to-back tables therefore sustain TABLE_SIZE·(NW+3)+1 cycles per table.
- rst together with start_equalize: rst wins and the block stays IDLE.

## Test plan
- Reset check: assert rst mid-clock with no clock edge → every output 0 immediately; busy = 0.
- Linear CDF: RAM model CDF[a] = (a+1)·300 with 1-cycle read latency, CDF_min = 300, defaults.
  - Pixels −128, 0, 127 in slots 0, 1, 63 → outputs 0, 128, 255.
  - equalized_valid exactly 1792 cycles after start, one cycle wide.
- Degenerate denominator: CDF_min = 76800, RAM returns 76800 everywhere → all 64 outputs 255.
- Underflow guard: CDF_min = 1000, RAM returns 500 → all outputs 0.
- Busy protocol: second start pulse at cycle 300 → ignored, one valid pulse only. Start in the valid cycle → second table completes 1792 cycles later. Also check that changing image_table after start does not alter results.
- Reset mid-operation: rst at cycle 500 → no valid pulse, equalized_table = 0. A fresh start then completes with correct values.
